memory_pipelined: RTL and testbench

- Parametrised successor to the single-cycle unified memory. One word-wide storage array serves a read-only instruction fetch port and a read/write data port.
- Adds byte-enable writes, a configurable registered read latency with valid-tagged responses, and a hardware clear sequencer that zeroes the array after reset.
- Sits between the hex core's fetch/execute stages and the storage. The core qualifies requests with o_ready.

---
 rtl/hex_pkg.sv | 12 +
 rtl/mem_resp_pipe.sv | 29 ++
 rtl/memory_pipelined.sv | 75 +++++++
 tb/tb_memory_pipelined.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// hex_pkg: shared memory geometry, typedefs and memory controller states
package hex_pkg;
  localparam int MEM_WIDTH = 32;
  localparam int MEM_DEPTH = 16384;
  localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);
  typedef logic [MEM_ADDR_WIDTH+$clog2(MEM_WIDTH/8)-1:0] iaddr_t;
  typedef logic [MEM_ADDR_WIDTH-1:0] waddr_t;
  typedef logic [MEM_WIDTH-1:0] data_t;
  typedef logic [7:0] instr_t;
  typedef logic [MEM_WIDTH/8-1:0] byte_en_t;
  typedef enum logic {CLEAR, READY} mem_state_e;
endpackage

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: valid-tagged response shift register whose data only advances with valid
module mem_resp_pipe #(
  parameter int WIDTH = 8,
  parameter int LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic [LATENCY-1:0] r_valid;
  logic [WIDTH-1:0]   r_data [LATENCY];
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) r_data[0] <= i_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        if (r_valid[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];
endmodule

// File: rtl/memory_pipelined.sv
// memory_pipelined: unified fetch/data memory with byte enables, pipelined reads and post-reset clear sweep
module memory_pipelined
  import hex_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_WIDTH,
  parameter int DEPTH = MEM_DEPTH,
  parameter int READ_LATENCY = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int BSEL_W = $clog2(BYTES),
  localparam int WADDR_W = $clog2(DEPTH),
  localparam int FADDR_W = WADDR_W + BSEL_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_ready,
  input  logic                  i_f_valid,
  input  logic [FADDR_W-1:0]    i_f_addr,
  output logic                  o_f_valid,
  output logic [7:0]            o_f_data,
  input  logic                  i_d_valid,
  input  logic                  i_d_we,
  input  logic [BYTES-1:0]      i_d_be,
  input  logic [WADDR_W-1:0]    i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_data,
  output logic                  o_d_valid,
  output logic [DATA_WIDTH-1:0] o_d_data
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  mem_state_e            r_state, w_state_nx;
  logic [WADDR_W-1:0]    r_cnt;
  logic                  w_clear, w_wr, w_d_pv, w_f_pv;
  logic [DATA_WIDTH-1:0] w_d_word, w_f_word, w_merge;
  logic [7:0]            w_f_byte;
  assign o_ready  = (r_state == READY) && !i_rst;
  assign w_clear  = r_state == CLEAR;
  assign w_wr     = i_d_valid && i_d_we && o_ready;
  assign w_d_word = r_mem[i_d_addr];
  assign w_f_word = r_mem[i_f_addr[FADDR_W-1:BSEL_W]];
  assign w_f_byte = w_f_word[{i_f_addr[BSEL_W-1:0], 3'b000} +: 8];
  always_comb w_state_nx = (w_clear && r_cnt == WADDR_W'(DEPTH - 1)) ? READY : r_state;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_clear ? r_cnt + 1'b1 : r_cnt;
    end
  always_comb begin
    w_merge = w_d_word;
    for (int i = 0; i < BYTES; i++) w_merge[8*i +: 8] = i_d_be[i] ? i_d_data[8*i +: 8] : w_d_word[8*i +: 8];
  end
  always_ff @(posedge i_clk)
    if (w_clear) r_mem[r_cnt] <= '0;
    else if (w_wr) r_mem[i_d_addr] <= w_merge;
  mem_resp_pipe #(.WIDTH(8), .LATENCY(READ_LATENCY)) u_f_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_f_valid && o_ready),
    .i_data  (w_f_byte),
    .o_valid (w_f_pv),
    .o_data  (o_f_data)
  );
  mem_resp_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_d_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_d_valid && !i_d_we && o_ready),
    .i_data  (w_d_word),
    .o_valid (w_d_pv),
    .o_data  (o_d_data)
  );
  assign o_f_valid = w_f_pv && !i_rst;
  assign o_d_valid = w_d_pv && !i_rst;
endmodule

// File: tb/tb_memory_pipelined.sv
// tb_memory_pipelined: scoreboard bench driving latency-1 and latency-3 instances with shared stimulus
module tb_memory_pipelined;
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        f_valid = 1'b0, d_valid = 1'b0, d_we = 1'b0;
  logic [5:0]  f_addr = '0;
  logic [3:0]  d_be = '0, d_addr = '0;
  logic [31:0] d_data = '0;
  logic        rdy1, fv1, dv1, rdy3, fv3, dv3;
  logic [7:0]  fd1, fd3;
  logic [31:0] dd1, dd3;
  exp_t        q[4][$];
  exp_t        e;
  logic [31:0] w, ed;
  logic [31:0] model[16];
  logic        ov[4];
  logic [31:0] od[4];
  logic        exp_v;
  logic        exp_rdy = 1'b0, chk_en = 1'b0;
  int          cyc = 0, clr_cnt = 0, n_tests = 0, n_fail = 0;
  string       names[4] = '{"d_l1", "f_l1", "d_l3", "f_l3"};
  always #5 clk = ~clk;
  memory_pipelined #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
    .i_clk(clk), .i_rst(rst), .o_ready(rdy1),
    .i_f_valid(f_valid), .i_f_addr(f_addr), .o_f_valid(fv1), .o_f_data(fd1),
    .i_d_valid(d_valid), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_data(d_data),
    .o_d_valid(dv1), .o_d_data(dd1)
  );
  memory_pipelined #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) u_l3 (
    .i_clk(clk), .i_rst(rst), .o_ready(rdy3),
    .i_f_valid(f_valid), .i_f_addr(f_addr), .o_f_valid(fv3), .o_f_data(fd3),
    .i_d_valid(d_valid), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_data(d_data),
    .o_d_valid(dv3), .o_d_data(dd3)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask
  // scoreboard producer: expectations taken from the model before this edge's write lands
  always @(posedge clk) begin
    if (!rst && exp_rdy) begin
      if (d_valid && !d_we) begin
        e.data = model[d_addr];
        e.due = cyc + 1; q[0].push_back(e);
        e.due = cyc + 3; q[2].push_back(e);
      end
      if (f_valid) begin
        w = model[f_addr[5:2]];
        e.data = (w >> (8 * f_addr[1:0])) & 32'hFF;
        e.due = cyc + 1; q[1].push_back(e);
        e.due = cyc + 3; q[3].push_back(e);
      end
      if (d_valid && d_we)
        for (int b = 0; b < 4; b++) if (d_be[b]) model[d_addr][8*b +: 8] = d_data[8*b +: 8];
    end
    if (rst) begin
      for (int p = 0; p < 4; p++) q[p].delete();
      for (int i = 0; i < 16; i++) model[i] = '0;
      exp_rdy = 1'b0;
      clr_cnt = 0;
    end else if (!exp_rdy) begin
      clr_cnt++;
      if (clr_cnt == 16) exp_rdy = 1'b1;
    end
    cyc++;
    chk_en = 1'b1;
  end
  // scoreboard consumer: every cycle each port's valid must match, and data when a response is due
  always @(negedge clk) if (chk_en) begin
    ov = '{dv1, fv1, dv3, fv3};
    od = '{dd1, {24'h0, fd1}, dd3, {24'h0, fd3}};
    chk("ready_l1", 32'(rdy1), 32'(exp_rdy && !rst));
    chk("ready_l3", 32'(rdy3), 32'(exp_rdy && !rst));
    for (int p = 0; p < 4; p++) begin
      exp_v = 1'b0;
      ed = '0;
      if (q[p].size() > 0 && q[p][0].due == cyc) begin
        exp_v = !rst;
        ed = q[p][0].data;
        void'(q[p].pop_front());
      end
      chk($sformatf("%s_valid", names[p]), 32'(ov[p]), 32'(exp_v));
      if (exp_v && ov[p]) chk($sformatf("%s_data", names[p]), od[p], ed);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic fv, input logic [5:0] fa, input logic dv, input logic we,
                     input logic [3:0] be, input logic [3:0] da, input logic [31:0] dd);
    f_valid = fv; f_addr = fa; d_valid = dv; d_we = we; d_be = be; d_addr = da; d_data = dd;
    step();
  endtask
  task automatic idle(input int n);
    repeat (n) req(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    req(1'b0, '0, 1'b1, 1'b1, be, a, d);
  endtask
  task automatic rd(input logic [3:0] a);
    req(1'b0, '0, 1'b1, 1'b0, '0, a, '0);
  endtask
  task automatic fe(input logic [5:0] a);
    req(1'b1, a, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic reset_pulse();
    f_valid = 1'b0; d_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (rdy1 !== 1'b1 && n < 64) begin
      idle(1);
      n++;
    end
    chk(tag, 32'(n), 32'd16);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step();
    step();
    @(negedge clk);
    chk("rst_d_data_l1", dd1, 32'h0);
    chk("rst_f_data_l1", {24'h0, fd1}, 32'h0);
    chk("rst_d_data_l3", dd3, 32'h0);
    chk("rst_f_data_l3", {24'h0, fd3}, 32'h0);
    step();
    rst = 1'b0;
    wait_ready("clear_cycles");
    for (int i = 0; i < 16; i++) req(1'b1, 6'(4 * i + (i % 4)), 1'b1, 1'b0, '0, 4'(i), '0);
    wr(4'd5, 32'hAABBCCDD, 4'hF);
    wr(4'd5, 32'h11223344, 4'b0101);
    wr(4'd5, 32'hFFFFFFFF, 4'h0);
    rd(4'd5);
    fe(6'd21);
    idle(4);
    for (int k = 0; k < 8; k++) wr(4'(k), 32'h100 + k, 4'hF);
    for (int k = 0; k < 8; k++) rd(4'(k));
    idle(4);
    wr(4'd2, 32'h44332211, 4'hF);
    for (int a = 8; a < 12; a++) fe(6'(a));
    idle(4);
    wr(4'd3, 32'h1, 4'hF);
    req(1'b1, 6'd12, 1'b1, 1'b1, 4'hF, 4'd3, 32'h2);
    req(1'b1, 6'd12, 1'b1, 1'b0, '0, 4'd3, '0);
    idle(4);
    reset_pulse();
    for (int i = 0; i < 16; i++) req(1'b1, 6'(4 * i), 1'b1, 1'(i % 2), 4'hF, 4'(i), 32'hFFFFFFFF);
    for (int i = 0; i < 16; i++) req(1'b1, 6'(4 * i + 1), 1'b1, 1'b0, '0, 4'(i), '0);
    rd(4'd1);
    rd(4'd2);
    reset_pulse();
    idle(7);
    reset_pulse();
    wait_ready("sweep_restart_cycles");
    repeat (300)
      req(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom), 4'($urandom), $urandom);
    idle(6);
    for (int p = 0; p < 4; p++) chk($sformatf("%s_drained", names[p]), 32'(q[p].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
